arb_req_buffer: RTL



---
 rtl/noc_pkg.sv | 9 +
 rtl/sync_fifo_ptr.sv | 39 +++
 rtl/arb_req_buffer.sv | 97 +++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC router defaults: flit width, flit type, starvation limit
package noc_pkg;

  localparam int NOC_DATA_WIDTH   = 64;
  localparam int NOC_STARVE_LIMIT = 15;

  typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/sync_fifo_ptr.sv
// rtl/sync_fifo_ptr.sv - FIFO pointer and occupancy bookkeeping (full/empty, rd/wr pointers)
module sync_fifo_ptr
  import noc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_buffer.sv
// rtl/arb_req_buffer.sv - per-input request buffer for the 2-input round-robin arbiter
// Optional starvation flag enabled by ARB_REQ_STARVE_CNT_EN.
module arb_req_buffer
  import noc_pkg::*;
#(
  parameter  int DATA_WIDTH   = NOC_DATA_WIDTH,
  parameter  int DEPTH        = 4,
`ifdef ARB_REQ_STARVE_CNT_EN
  parameter  int STARVE_LIMIT = NOC_STARVE_LIMIT,
`endif
  localparam int PTR_W        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  rq,
  input  logic                  gt,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PTR_W:0]        count
`ifdef ARB_REQ_STARVE_CNT_EN
  ,
  output logic                  starve
`endif
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // rq and in_rdy come only from registered occupancy, keeping the arbiter loop open
  assign in_rdy = ~full;
  assign rq     = ~empty;
  assign push   = in_vld & in_rdy;
  assign pop    = rq & gt;

  sync_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld <= pop;
      if (pop) out_data <= mem[rd_ptr];
    end
  end

`ifdef ARB_REQ_STARVE_CNT_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starve_hit;

  // flag rises on the same edge the counter reaches the limit
  assign starve_hit = rq & ~gt & (starve_cnt >= SW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      if (pop || !rq)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
      if (pop)
        starve <= 1'b0;
      else if (starve_hit)
        starve <= 1'b1;
    end
  end
`endif

endmodule
